// File: rtl/sap1_pkg.sv
// Shared SAP-1 definitions for the program/data RAM arbiter: default widths,
// arbiter FSM states and requester identifiers.
package sap1_pkg;

   localparam int SAP1_ADDR_W = 4;
   localparam int SAP1_DATA_W = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      WAIT   = 2'd2,
      DONE   = 2'd3
   } arb_state_t;

   typedef enum logic {
      REQ_LD  = 1'b0,
      REQ_CPU = 1'b1
   } req_id_t;

endpackage

// File: rtl/ram_arbiter_rr_arb2.sv
// Two-way round-robin pick between the program loader and the CPU.
// Purely combinational; the caller owns the last_grant register.
module rr_arb2
   import sap1_pkg::*;
(
   input  logic    ld_req_eff,
   input  logic    cpu_req_eff,
   input  req_id_t last_grant,
   output req_id_t winner,
   output logic    grant_valid
);

   always_comb begin
      winner = REQ_LD;
      if (ld_req_eff && cpu_req_eff) begin
         // on a tie the side that did not win last time goes next
         winner = (last_grant == REQ_LD) ? REQ_CPU : REQ_LD;
      end else if (cpu_req_eff) begin
         winner = REQ_CPU;
      end
   end

   assign grant_valid = ld_req_eff | cpu_req_eff;

endmodule

// File: rtl/ram_arbiter.sv
// Shares the single-port SAP-1 RAM between the program loader and the CPU.
// Optional grant counters are enabled by defining RAM_ARB_STATS_EN.
//
// state  | meaning
// IDLE   | no transaction; arbitrate and latch the winner's payload
// ACCESS | RAM sees address/data, ram_we high for this single cycle
// WAIT   | ram_dout valid; captured into the owner's rdata at exit
// DONE   | owner's ack high for this single cycle
module ram_arbiter
   import sap1_pkg::*;
#(
   parameter int ADDR_W = SAP1_ADDR_W,
   parameter int DATA_W = SAP1_DATA_W,
   parameter int STAT_W = 8
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic              prog_mode,
   input  logic              ld_req,
   input  logic              ld_we,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [DATA_W-1:0] ld_wdata,
   output logic              ld_ack,
   output logic [DATA_W-1:0] ld_rdata,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_ack,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_din,
   input  logic [DATA_W-1:0] ram_dout,
   output logic              busy
`ifdef RAM_ARB_STATS_EN
   ,output logic [STAT_W-1:0] ld_grants,
   output logic [STAT_W-1:0] cpu_grants
`endif
);

   arb_state_t        state_q, state_d;
   req_id_t           last_grant_q, owner_q, winner;
   logic              grant_valid, cpu_req_eff, grant_now;
   logic              ram_we_q, ld_ack_q, cpu_ack_q, busy_q;
   logic [ADDR_W-1:0] ram_addr_q;
   logic [DATA_W-1:0] ram_din_q, ld_rdata_q, cpu_rdata_q;

   assign cpu_req_eff = cpu_req & ~prog_mode;
   assign grant_now   = (state_q == IDLE) && grant_valid;

   rr_arb2 u_rr_arb2 (
      .ld_req_eff  (ld_req),
      .cpu_req_eff (cpu_req_eff),
      .last_grant  (last_grant_q),
      .winner      (winner),
      .grant_valid (grant_valid)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (grant_valid) state_d = ACCESS;
         ACCESS:  state_d = WAIT;
         WAIT:    state_d = DONE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         last_grant_q <= REQ_CPU;
         owner_q      <= REQ_LD;
         ram_we_q     <= 1'b0;
         ram_addr_q   <= '0;
         ram_din_q    <= '0;
         ld_ack_q     <= 1'b0;
         cpu_ack_q    <= 1'b0;
         ld_rdata_q   <= '0;
         cpu_rdata_q  <= '0;
         busy_q       <= 1'b0;
      end else begin
         state_q   <= state_d;
         busy_q    <= (state_d != IDLE);
         ram_we_q  <= 1'b0;
         ld_ack_q  <= 1'b0;
         cpu_ack_q <= 1'b0;
         if (grant_now) begin
            owner_q      <= winner;
            last_grant_q <= winner;
            if (winner == REQ_LD) begin
               ram_addr_q <= ld_addr;
               ram_din_q  <= ld_wdata;
               ram_we_q   <= ld_we;
            end else begin
               ram_addr_q <= cpu_addr;
               ram_din_q  <= cpu_wdata;
               ram_we_q   <= cpu_we;
            end
         end
         // rdata and ack are loaded together so rdata is valid for the whole ack cycle
         if (state_q == WAIT) begin
            if (owner_q == REQ_LD) begin
               ld_rdata_q <= ram_dout;
               ld_ack_q   <= 1'b1;
            end else begin
               cpu_rdata_q <= ram_dout;
               cpu_ack_q   <= 1'b1;
            end
         end
      end
   end

   assign ram_we    = ram_we_q;
   assign ram_addr  = ram_addr_q;
   assign ram_din   = ram_din_q;
   assign ld_ack    = ld_ack_q;
   assign cpu_ack   = cpu_ack_q;
   assign ld_rdata  = ld_rdata_q;
   assign cpu_rdata = cpu_rdata_q;
   assign busy      = busy_q;

`ifdef RAM_ARB_STATS_EN
   logic [STAT_W-1:0] ld_grants_q, cpu_grants_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ld_grants_q  <= '0;
         cpu_grants_q <= '0;
      end else if (grant_now) begin
         if (winner == REQ_LD && !(&ld_grants_q))
            ld_grants_q <= ld_grants_q + 1'b1;
         if (winner == REQ_CPU && !(&cpu_grants_q))
            cpu_grants_q <= cpu_grants_q + 1'b1;
      end
   end

   assign ld_grants  = ld_grants_q;
   assign cpu_grants = cpu_grants_q;
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed handshake/priority cases plus random traffic,
// all outputs compared every cycle against a transaction-level model.
module tb_ram_arbiter;

   localparam int AW = 4;
   localparam int DW = 8;
   localparam int SW = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          prog_mode, ld_req, ld_we, cpu_req, cpu_we;
   logic [AW-1:0] ld_addr, cpu_addr, ram_addr;
   logic [DW-1:0] ld_wdata, cpu_wdata, ld_rdata, cpu_rdata, ram_din, ram_dout;
   logic          ld_ack, cpu_ack, ram_we, busy;
`ifdef RAM_ARB_STATS_EN
   logic [SW-1:0] ld_grants, cpu_grants;
`endif

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STAT_W(SW)) dut (
      .clk(clk), .rst(rst), .prog_mode(prog_mode),
      .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
      .ld_ack(ld_ack), .ld_rdata(ld_rdata),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
      .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout),
      .busy(busy)
`ifdef RAM_ARB_STATS_EN
      ,.ld_grants(ld_grants), .cpu_grants(cpu_grants)
`endif
   );

   // synchronous write-first RAM, contents survive arbiter reset
   logic [DW-1:0] mem [16] = '{default: 8'h00};
   always @(posedge clk) begin
      if (ram_we) begin
         mem[ram_addr] <= ram_din;
         ram_dout      <= ram_din;
      end else begin
         ram_dout <= mem[ram_addr];
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      else n_pass++;
   endtask

   // Transaction-level model: a transaction occupies 4 cycles counted from its
   // grant edge; the RAM operation happens one edge after the grant.
   logic [DW-1:0] shadow [16] = '{default: 8'h00};
   int            remain;
   bit            m_who, m_last, m_we;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata, m_rd;
   logic          e_ram_we, e_ld_ack, e_cpu_ack, e_busy;
   logic [AW-1:0] e_ram_addr;
   logic [DW-1:0] e_ram_din, e_ld_rdata, e_cpu_rdata;
   int            e_ld_grants, e_cpu_grants;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         remain = 0; m_last = 1'b1; m_who = 1'b0; m_we = 1'b0;
         m_addr = '0; m_wdata = '0; m_rd = '0;
         e_ram_we = 0; e_ld_ack = 0; e_cpu_ack = 0; e_busy = 0;
         e_ram_addr = '0; e_ram_din = '0; e_ld_rdata = '0; e_cpu_rdata = '0;
         e_ld_grants = 0; e_cpu_grants = 0;
      end else begin
         e_ram_we = 0; e_ld_ack = 0; e_cpu_ack = 0;
         if (remain == 0) begin
            bit l, c;
            l = ld_req;
            c = cpu_req && !prog_mode;
            if (l || c) begin
               m_who  = (l && c) ? !m_last : c;
               m_last = m_who;
               m_we    = m_who ? cpu_we : ld_we;
               m_addr  = m_who ? cpu_addr : ld_addr;
               m_wdata = m_who ? cpu_wdata : ld_wdata;
               e_ram_we = m_we; e_ram_addr = m_addr; e_ram_din = m_wdata;
               if (m_who) e_cpu_grants = (e_cpu_grants == 3) ? 3 : e_cpu_grants + 1;
               else       e_ld_grants  = (e_ld_grants  == 3) ? 3 : e_ld_grants + 1;
               remain = 3;
            end
         end else if (remain == 3) begin
            m_rd = m_we ? m_wdata : shadow[m_addr];
            if (m_we) shadow[m_addr] = m_wdata;
            remain = 2;
         end else if (remain == 2) begin
            if (m_who) begin e_cpu_ack = 1; e_cpu_rdata = m_rd; end
            else       begin e_ld_ack  = 1; e_ld_rdata  = m_rd; end
            remain = 1;
         end else begin
            remain = 0;
         end
         e_busy = (remain != 0);
      end
   end

   always @(negedge clk) begin
      if (rst) begin
         check("ram_we",    ram_we,    e_ram_we);
         check("ram_addr",  ram_addr,  e_ram_addr);
         check("ram_din",   ram_din,   e_ram_din);
         check("ld_ack",    ld_ack,    e_ld_ack);
         check("cpu_ack",   cpu_ack,   e_cpu_ack);
         check("ld_rdata",  ld_rdata,  e_ld_rdata);
         check("cpu_rdata", cpu_rdata, e_cpu_rdata);
         check("busy",      busy,      e_busy);
`ifdef RAM_ARB_STATS_EN
         check("ld_grants",  ld_grants,  e_ld_grants);
         check("cpu_grants", cpu_grants, e_cpu_grants);
`endif
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ack(input int budget, output bit got_ld, output bit got_cpu);
      got_ld = 0; got_cpu = 0;
      for (int i = 0; i < budget; i++) begin
         tick();
         if (ld_ack || cpu_ack) begin
            got_ld = ld_ack; got_cpu = cpu_ack;
            break;
         end
      end
      if (!got_ld && !got_cpu) check("ack_timeout", 0, 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation still running, required to finish");
      $fatal(1);
   end

   initial begin
      bit gl, gc, overlap, masked_ok;
      bit order [4];
      prog_mode = 0; ld_req = 0; ld_we = 0; ld_addr = '0; ld_wdata = '0;
      cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
      #1;
      check("rst_ram_we", ram_we, 0);
      check("rst_busy", busy, 0);
      check("rst_acks", {ld_ack, cpu_ack}, 0);
      check("rst_addr_din", {ram_addr, ram_din}, 0);
      repeat (3) @(posedge clk);
      #3 rst = 1;

      // loader write 3 <- 56 in program mode
      tick();
      prog_mode = 1; ld_req = 1; ld_we = 1; ld_addr = 4'h3; ld_wdata = 8'h56;
      tick();
      check("wr_ram_we_on", ram_we, 1);
      check("wr_ram_addr", ram_addr, 4'h3);
      check("wr_ram_din", ram_din, 8'h56);
      tick();
      check("wr_ram_we_off", ram_we, 0);
      check("wr_no_ack_early", ld_ack, 0);
      tick();
      check("wr_ld_ack", ld_ack, 1);
      check("wr_cpu_ack", cpu_ack, 0);
      check("wr_rdata", ld_rdata, 8'h56);
      ld_req = 0;
      tick();
      check("wr_ack_pulse", ld_ack, 0);

      // read-back
      ld_req = 1; ld_we = 0; ld_wdata = 8'hFF;
      tick(); tick(); tick();
      check("rd_ld_ack", ld_ack, 1);
      check("rd_rdata", ld_rdata, 8'h56);
      ld_req = 0;
      tick();

      // CPU masked while prog_mode is high
      cpu_req = 1; cpu_we = 0; cpu_addr = 4'h3;
      masked_ok = 1;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (cpu_ack || busy) masked_ok = 0;
      end
      check("pm_masked", masked_ok, 1);
      prog_mode = 0;
      tick(); tick();
      check("pm_no_ack_early", cpu_ack, 0);
      tick();
      check("pm_cpu_ack", cpu_ack, 1);
      check("pm_cpu_rdata", cpu_rdata, 8'h56);
      cpu_req = 0;
      tick();

      // round-robin with both held; last grant was CPU so loader goes first
      ld_req = 1; ld_addr = 4'h1; cpu_req = 1; cpu_addr = 4'h2;
      overlap = 0;
      for (int k = 0; k < 4; k++) begin
         wait_ack(12, gl, gc);
         if (gl && gc) overlap = 1;
         order[k] = gc;
         if (k == 3) begin ld_req = 0; cpu_req = 0; end
      end
      check("rr_overlap", overlap, 0);
      check("rr_order", {order[0], order[1], order[2], order[3]}, 4'b0101);
      tick();

      // reset during ACCESS of a write: write aborted, no ack, first tie to loader
      ld_req = 1; ld_we = 1; ld_addr = 4'h7; ld_wdata = 8'hAA;
      tick();
      check("rm_we_before", ram_we, 1);
      #2 rst = 0;
      #1;
      check("rm_we_async", ram_we, 0);
      check("rm_busy", busy, 0);
      ld_req = 0;
      tick(); tick();
      check("rm_no_ack", {ld_ack, cpu_ack}, 0);
      #2 rst = 1;
      ld_req = 1; ld_we = 0; cpu_req = 1; cpu_we = 0; cpu_addr = 4'h3;
      wait_ack(12, gl, gc);
      check("rm_first_tie_ld", {gl, gc}, 2'b10);
      check("rm_write_aborted", ld_rdata, 8'h00);
      ld_req = 0;
      wait_ack(12, gl, gc);
      check("rm_then_cpu", {gl, gc}, 2'b01);
      cpu_req = 0;
      tick();

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         tick();
         if (($urandom % 40) == 0) prog_mode = ~prog_mode;
         if ((ld_req && ld_ack) || (!ld_req && ($urandom % 4) == 0)) begin
            ld_req   = ld_req ? (($urandom % 3) == 0) : 1'b1;
            ld_we    = $urandom % 2;
            ld_addr  = $urandom % 16;
            ld_wdata = $urandom % 256;
         end
         if ((cpu_req && cpu_ack) || (!cpu_req && ($urandom % 4) == 0)) begin
            cpu_req   = cpu_req ? (($urandom % 3) == 0) : 1'b1;
            cpu_we    = $urandom % 2;
            cpu_addr  = $urandom % 16;
            cpu_wdata = $urandom % 256;
         end
      end
`ifdef RAM_ARB_STATS_EN
      check("stats_ld_sat", ld_grants, 2'd3);
`endif
      tick();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
